// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM states, frame geometry
// and the baud divisor rounding helper (also intended for the receive side).
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // start + 8 data + stop
  localparam int   UART_FRAME_BITS = 10;
  localparam int   UART_DATA_BITS  = UART_FRAME_BITS - 2;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Nearest-integer clocks per bit; rounding keeps the baud error below half a clock.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO with extended pointers (one wrap bit above the address)
// and a registered read port: rd_data is valid the cycle after rd_en.
module uart_tx_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]    rd_data_q;
  logic                push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

  // Overflowing writes and underflowing reads are ignored rather than corrupting pointers.
  assign push = wr_en & ~full;
  assign pop  = rd_en & ~empty;

  // Pointer advance; the extra MSB toggles on each wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Storage array; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
  end

  // Pointers and registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (pop) rd_data_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, small FIFO, 8N1 serialiser
// (idle high, LSB first). tx is a flop output so the pin never glitches.
//
// state | meaning
// IDLE  | line at mark; pop the FIFO as soon as it holds a byte
// START | start bit (0) for CLKS_PER_BIT cycles; popped byte lands in shifter
// DATA  | bits 0..7 from the shifter, CLKS_PER_BIT cycles each
// STOP  | stop bit (1); pops straight into the next START if a byte waits
//
// tx and busy are registered from the current state, so the line trails the
// state by one clock. Combined with the one-cycle FIFO read this gives a
// two-edge accept-to-start-bit latency and back-to-back frames with no gap.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_HZ       = 16000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD),
  parameter int DEPTH_LOG2   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [UART_DATA_BITS-1:0] data,
  input  logic                      valid,
  output logic                      ready,
  output logic                      tx,
  output logic                      busy
);

  localparam int               DIV_W    = $clog2(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      rdy_en_q;
  logic                      div_tc;

  logic                      fifo_wr_en;
  logic                      fifo_rd_en;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_rd_data;

  // ready depends only on flops: a reset-release gate and the FIFO pointers.
  assign ready      = rdy_en_q & ~fifo_full;
  assign fifo_wr_en = valid & ready;
  assign div_tc     = (div_q == DIV_LAST);

  uart_tx_sync_fifo #(
    .WIDTH      (UART_DATA_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr_en),
    .wr_data (data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state, divider, bit index, shifter and FIFO pop decisions.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fifo_rd_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        div_d     = '0;
        bit_idx_d = '0;
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        if (div_tc) begin
          div_d     = '0;
          bit_idx_d = '0;
          // FIFO read data has been stable since the cycle after the pop.
          shift_d   = fifo_rd_data;
          state_d   = ST_DATA;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (div_tc) begin
          div_d   = '0;
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (bit_idx_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (div_tc) begin
          div_d = '0;
          if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            state_d    = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
      end
    endcase
  end

  // Line level and busy flag for the next clock, derived from the present state.
  always_comb begin
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = UART_IDLE_LEVEL;
    endcase
    busy_d = (state_q != ST_IDLE) | ~fifo_empty;
  end

  // State register; reset abandons any frame and forces the line to mark.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      rdy_en_q  <= 1'b1;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
